// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencing controller: default size,
// scheduler state type and the address bit-manipulation helpers.
package fft_pkg;

  localparam int FFT_LOG2N = 6;
  localparam int FFT_N     = 1 << FFT_LOG2N;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_RD = 3'd1,
    ST_RUN_WR = 3'd2,
    ST_OUT    = 3'd3,
    ST_DONE   = 3'd4
  } fft_sched_state_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) r[w-1-b] = v[b];
    end
    return r;
  endfunction

  // Rotate the low w bits of v left by sh positions.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int sh, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < w) r[(b + sh) % w] = v[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: maps (level, iteration) to the two operand
// addresses of an in-place radix-2 DIT butterfly and its twiddle index.
module fft_agu
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int AW    = LOG2N,
  parameter int TW    = LOG2N - 1,
  parameter int LW    = $clog2(LOG2N + 1)
) (
  input  logic [LW-1:0] level_i,
  input  logic [TW-1:0] iter_i,
  output logic [AW-1:0] ja_o,
  output logic [AW-1:0] jb_o,
  output logic [TW-1:0] tw_o
);

  // Operand pair is the iteration index with a 0/1 appended, rotated by the
  // level; the twiddle keeps only the top 'level' bits of the iteration.
  always_comb begin
    ja_o = AW'(rotl(32'({iter_i, 1'b0}), int'(level_i), AW));
    jb_o = AW'(rotl(32'({iter_i, 1'b1}), int'(level_i), AW));
    if (int'(level_i) >= TW) begin
      tw_o = iter_i;
    end else begin
      tw_o = iter_i & ~TW'((32'd1 << (TW - int'(level_i))) - 32'd1);
    end
  end

endmodule

// File: rtl/fft_scheduler.sv
// FFT sequencing controller. Loads samples into ram0, runs LOG2N butterfly
// levels ping-ponging between ram0 and ram1 (two cycles per butterfly to
// cover the BRAM read latency), then streams the N results out of ram0.
// Optional build macro FFT_SCHED_BITREV_LOAD_EN: bit-reverse the load
// address in hardware so the host can supply samples in natural order.
module fft_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int AW    = LOG2N,
  parameter int TW    = LOG2N - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load,
  input  logic [AW-1:0] load_address,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram0_addr_a,
  output logic [AW-1:0] ram0_addr_b,
  output logic          ram0_we,
  output logic [AW-1:0] ram1_addr_a,
  output logic [AW-1:0] ram1_addr_b,
  output logic          ram1_we,
  output logic          wdata_sel,
  output logic          rd_sel,
  output logic [TW-1:0] twiddle_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_index
);

  localparam int LW   = $clog2(LOG2N + 1);
  localparam int NPTS = 1 << LOG2N;

  // Results only land back in ram0 when the last level is odd.
  if ((LOG2N % 2) != 0) begin : g_log2n_odd
    $error("fft_scheduler: LOG2N must be even so results land in ram0");
  end

  fft_sched_state_t state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [TW-1:0]    iter_q, iter_d;
  logic [AW:0]      k_q, k_d;
  logic             out_valid_q, out_valid_d;
  logic [AW-1:0]    out_index_q, out_index_d;

  logic [AW-1:0]    ja, jb, ld_addr;
  logic [TW-1:0]    tw;

  fft_agu #(
    .LOG2N (LOG2N),
    .AW    (AW),
    .TW    (TW),
    .LW    (LW)
  ) u_agu (
    .level_i (level_q),
    .iter_i  (iter_q),
    .ja_o    (ja),
    .jb_o    (jb),
    .tw_o    (tw)
  );

`ifdef FFT_SCHED_BITREV_LOAD_EN
  assign ld_addr = AW'(bitrev(32'(load_address), AW));
`else
  assign ld_addr = load_address;
`endif

  // State, counters and the one-cycle-delayed readout tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      iter_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      iter_q      <= iter_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  // Next-state sequencing and all RAM/ROM control strobes.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    iter_d       = iter_q;
    k_d          = k_q;
    busy         = 1'b0;
    done         = 1'b0;
    ram0_addr_a  = '0;
    ram0_addr_b  = '0;
    ram0_we      = 1'b0;
    ram1_addr_a  = '0;
    ram1_addr_b  = '0;
    ram1_we      = 1'b0;
    wdata_sel    = 1'b0;
    rd_sel       = 1'b0;
    twiddle_addr = '0;
    // A read issued in OUT (k < N) shows up on data_out one cycle later.
    out_valid_d  = (state_q == ST_OUT) && !k_q[AW];
    out_index_d  = k_q[AW-1:0];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          // start has priority: the coincident load is dropped.
          state_d = ST_RUN_RD;
          level_d = '0;
          iter_d  = '0;
        end else if (load) begin
          ram0_we     = 1'b1;
          ram0_addr_a = ld_addr;
          ram0_addr_b = ld_addr;
          state_d     = ST_IDLE;
        end
      end

      ST_RUN_RD: begin
        busy         = 1'b1;
        rd_sel       = level_q[0];
        twiddle_addr = tw;
        ram0_addr_a  = ja;
        ram0_addr_b  = jb;
        ram1_addr_a  = ja;
        ram1_addr_b  = jb;
        state_d      = ST_RUN_WR;
      end

      ST_RUN_WR: begin
        busy         = 1'b1;
        rd_sel       = level_q[0];
        twiddle_addr = tw;
        wdata_sel    = 1'b1;
        ram0_addr_a  = ja;
        ram0_addr_b  = jb;
        ram1_addr_a  = ja;
        ram1_addr_b  = jb;
        // Destination is whichever RAM is not the source for this level.
        ram0_we      = level_q[0];
        ram1_we      = ~level_q[0];
        state_d      = ST_RUN_RD;
        if (iter_q == TW'(NPTS / 2 - 1)) begin
          iter_d  = '0;
          level_d = level_q + 1'b1;
          if (level_q == LW'(LOG2N - 1)) begin
            state_d = ST_OUT;
            k_d     = '0;
          end
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end

      ST_OUT: begin
        busy = 1'b1;
        if (!k_q[AW]) begin
          ram0_addr_a = k_q[AW-1:0];
          k_d         = k_q + 1'b1;
        end else begin
          // Drain cycle: the last sample is on data_out now.
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_fft_scheduler.sv
// Bench for fft_scheduler: surrounds the controller with behavioural RAMs,
// a twiddle ROM and a complex butterfly, and scores streamed results against
// a direct DFT of the loaded samples.
module tb_fft_scheduler;

  localparam int LOG2N = 6;
  localparam int N     = 1 << LOG2N;
  localparam int AW    = LOG2N;
  localparam int TW    = LOG2N - 1;
  localparam int NB    = N / 2;
  localparam real PI   = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          reset, start, load;
  logic [AW-1:0] load_address;
  logic          busy, done, ram0_we, ram1_we, wdata_sel, rd_sel, out_valid;
  logic [AW-1:0] ram0_addr_a, ram0_addr_b, ram1_addr_a, ram1_addr_b, out_index;
  logic [TW-1:0] twiddle_addr;

  fft_scheduler #(.LOG2N(LOG2N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load         (load),
    .load_address (load_address),
    .busy         (busy),
    .done         (done),
    .ram0_addr_a  (ram0_addr_a),
    .ram0_addr_b  (ram0_addr_b),
    .ram0_we      (ram0_we),
    .ram1_addr_a  (ram1_addr_a),
    .ram1_addr_b  (ram1_addr_b),
    .ram1_we      (ram1_we),
    .wdata_sel    (wdata_sel),
    .rd_sel       (rd_sel),
    .twiddle_addr (twiddle_addr),
    .out_valid    (out_valid),
    .out_index    (out_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- datapath environment ----------------
  real m0re[N], m0im[N], m1re[N], m1im[N];
  real r0a_re, r0a_im, r0b_re, r0b_im, r1a_re, r1a_im, r1b_re, r1b_im;
  real load_re = 0.0, load_im = 0.0;
  real e_are, e_aim, e_bre, e_bim, e_wre, e_wim, e_tre, e_tim;
  real x_are, x_aim, x_bre, x_bim;
  logic [TW-1:0] tw_q;

  always @(posedge clk) begin
    if (wdata_sel) begin
      e_are = rd_sel ? r1a_re : r0a_re;
      e_aim = rd_sel ? r1a_im : r0a_im;
      e_bre = rd_sel ? r1b_re : r0b_re;
      e_bim = rd_sel ? r1b_im : r0b_im;
      e_wre = $cos(2.0 * PI * real'(int'(tw_q)) / real'(N));
      e_wim = -$sin(2.0 * PI * real'(int'(tw_q)) / real'(N));
      e_tre = e_bre * e_wre - e_bim * e_wim;
      e_tim = e_bre * e_wim + e_bim * e_wre;
      x_are = e_are + e_tre; x_aim = e_aim + e_tim;
      x_bre = e_are - e_tre; x_bim = e_aim - e_tim;
    end else begin
      x_are = load_re; x_aim = load_im;
      x_bre = load_re; x_bim = load_im;
    end
    if (ram0_we) begin
      m0re[ram0_addr_a] <= x_are; m0im[ram0_addr_a] <= x_aim;
      m0re[ram0_addr_b] <= x_bre; m0im[ram0_addr_b] <= x_bim;
    end
    if (ram1_we) begin
      m1re[ram1_addr_a] <= x_are; m1im[ram1_addr_a] <= x_aim;
      m1re[ram1_addr_b] <= x_bre; m1im[ram1_addr_b] <= x_bim;
    end
    r0a_re <= m0re[ram0_addr_a]; r0a_im <= m0im[ram0_addr_a];
    r0b_re <= m0re[ram0_addr_b]; r0b_im <= m0im[ram0_addr_b];
    r1a_re <= m1re[ram1_addr_a]; r1a_im <= m1im[ram1_addr_a];
    r1b_re <= m1re[ram1_addr_b]; r1b_im <= m1im[ram1_addr_b];
    tw_q   <= twiddle_addr;
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int idx; real re; real im; } exp_t;
  exp_t sbq[$];
  real  mre[N], mim[N];   // expected ram0 image, RAM-address order
  int   run_id = 0;
  int   start_cyc = 0;

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  task automatic chk_int(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Direct DFT of the sample order the butterflies expect (bit-reversed in
  // RAM); results replace the ram0 image since the transform is in place.
  task automatic push_expected();
    real xr[N], xi[N], ar, ai, ang;
    for (int k = 0; k < N; k++) begin
      ar = 0.0; ai = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = -2.0 * PI * real'((n * k) % N) / real'(N);
        ar += mre[brev(n)] * $cos(ang) - mim[brev(n)] * $sin(ang);
        ai += mre[brev(n)] * $sin(ang) + mim[brev(n)] * $cos(ang);
      end
      xr[k] = ar; xi[k] = ai;
    end
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.idx = k; e.re = xr[k]; e.im = xi[k];
      sbq.push_back(e);
      mre[k] = xr[k]; mim[k] = xi[k];
    end
  endtask

  // ---------------- monitor ----------------
  int   seen_id = 0, wcnt = 0, n0 = 0, n1 = 0, ocnt = 0;
  bit   first_ov = 1'b1, prev_ov = 1'b0;

  initial begin
    exp_t e;
    int   lv, it, g, pos, s, eja, ejb, etw;
    real  tol;
    forever begin
      @(negedge clk);
      if (run_id != seen_id) begin
        seen_id = run_id; wcnt = 0; n0 = 0; n1 = 0; ocnt = 0; first_ov = 1'b1;
      end
      if (reset && busy && wdata_sel && (ram0_we || ram1_we)) begin
        lv  = wcnt / NB; it = wcnt % NB;
        g   = it % (1 << (TW - lv)); pos = it >> (TW - lv); s = 1 << lv;
        eja = g * 2 * s + pos; ejb = eja + s; etw = pos << (TW - lv);
        if (lv % 2 == 1)
          chk_int("butterfly", {ram0_we, ram1_we, ram0_addr_a, ram0_addr_b, twiddle_addr, rd_sel},
                  {2'b10, 6'(eja), 6'(ejb), 5'(etw), 1'b1});
        else
          chk_int("butterfly", {ram0_we, ram1_we, ram1_addr_a, ram1_addr_b, twiddle_addr, rd_sel},
                  {2'b01, 6'(eja), 6'(ejb), 5'(etw), 1'b0});
        if (ram0_we) n0++;
        if (ram1_we) n1++;
        wcnt++;
      end
      if (out_valid) begin
        if (first_ov) begin
          chk_int("latency", cyc - start_cyc, N * LOG2N + 1);
          first_ov = 1'b0;
        end
        if (sbq.size() == 0) begin
          chk_int("unexpected_output", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk_int("out_index", out_index, e.idx);
          tol = 1.0e-6 * (1.0 + (e.re < 0 ? -e.re : e.re) + (e.im < 0 ? -e.im : e.im));
          checks++;
          if ((r0a_re - e.re > tol) || (e.re - r0a_re > tol) ||
              (r0a_im - e.im > tol) || (e.im - r0a_im > tol)) begin
            errors++;
            $display("FAIL data[%0d]: got (%f,%f) expected (%f,%f)",
                     e.idx, r0a_re, r0a_im, e.re, e.im);
          end
        end
        ocnt++;
      end
      if (prev_ov && !out_valid) begin
        chk_int("out_run_length", ocnt, N);
        chk_int("done_after_out", done, 1);
        chk_int("we_pulses", {n0[15:0], n1[15:0]}, {16'(N * LOG2N / 4), 16'(N * LOG2N / 4)});
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_sample(input int n, input real re, input real im);
    @(negedge clk);
    load = 1'b1;
`ifdef FFT_SCHED_BITREV_LOAD_EN
    load_address = AW'(n);
`else
    load_address = AW'(brev(n));
`endif
    load_re = re; load_im = im;
    #1;
    chk_int("load_addr", {ram0_we, wdata_sel, ram0_addr_a, ram0_addr_b},
            {1'b1, 1'b0, 6'(brev(n)), 6'(brev(n))});
    mre[brev(n)] = re; mim[brev(n)] = im;
  endtask

  task automatic load_random();
    for (int n = 0; n < N; n++)
      load_sample(n, real'(int'($urandom_range(100)) - 50), real'(int'($urandom_range(100)) - 50));
    @(negedge clk) load = 1'b0;
  endtask

  task automatic start_run(input bit with_load);
    @(negedge clk);
    start = 1'b1;
    load  = with_load;
    load_address = AW'($urandom_range(N - 1));
    load_re = 999.0; load_im = -999.0;
    run_id++;
    if (with_load) begin
      #1 chk_int("collision_no_write", ram0_we, 0);
    end
    push_expected();
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    start_cyc = cyc;
    chk_int("run_entered", {busy, done}, 2'b10);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 1000) begin
      @(negedge clk); t++;
    end
    if (!done) chk_int("done_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load = 1'b0; load_address = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_outputs",
            {busy, done, ram0_addr_a, ram0_addr_b, ram0_we, ram1_addr_a, ram1_addr_b, ram1_we,
             wdata_sel, rd_sel, twiddle_addr, out_valid, out_index}, 0);
    reset = 1'b1;

    // Impulse at sample 0: flat spectrum of ones.
    for (int n = 0; n < N; n++) load_sample(n, (n == 0) ? 1.0 : 0.0, 0.0);
    @(negedge clk) load = 1'b0;
    start_run(1'b0);
    // start/load while busy must be ignored (latency check covers it).
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom_range(1)); load = 1'($urandom_range(1));
      load_address = AW'($urandom_range(N - 1));
    end
    @(negedge clk) begin start = 1'b0; load = 1'b0; end
    wait_done();
    repeat (4) begin
      @(negedge clk) chk_int("done_held", {busy, done}, 2'b01);
    end

    // Random data; the first load leaves DONE.
    load_sample(0, 3.0, -2.0);
    @(negedge clk) begin
      load = 1'b0;
      chk_int("load_drops_done", done, 0);
    end
    load_random();
    start_run(1'b1);
    wait_done();

    // In-place re-run on the previous results.
    start_run(1'b0);
    wait_done();

    // Asynchronous reset in the middle of a level-3 write.
    load_random();
    start_run(1'b0);
    begin
      int t = 0;
      while (!(busy && wdata_sel && ram0_we && (cyc - start_cyc) >= 3 * N + 8) && t < 1000) begin
        @(negedge clk); t++;
      end
      if (t >= 1000) chk_int("level3_timeout", 0, 1);
    end
    reset = 1'b0;
    #1;
    chk_int("midrun_reset",
            {busy, done, ram0_addr_a, ram0_addr_b, ram0_we, ram1_addr_a, ram1_addr_b, ram1_we,
             wdata_sel, rd_sel, twiddle_addr, out_valid, out_index}, 0);
    sbq.delete();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk_int("idle_after_reset", {busy, done}, 2'b00);

    load_random();
    start_run(1'b0);
    wait_done();

    repeat (2) @(negedge clk);
    chk_int("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
